instr_loader: RTL
=================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter ROM_WIDTH, default 12: width of the byte offset into instruction memory; capacity is 2**ROM_WIDTH bytes.
REQ-002 Parameter DATA_WIDTH, default 32: instruction word width; informational only, since bytes are written singly.
REQ-003 Port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: single-cycle pulse that begins a load session; honoured in IDLE, DONE and ERR only.
REQ-006 Port rx_valid, input, 1: a byte is offered on rx_data.
REQ-007 Port rx_data, input, 8: stream byte.
REQ-008 Port rx_ready, output, 1: loader accepts a byte this cycle; a transfer occurs when rx_valid and rx_ready are both high.
REQ-009 Port mem_we, output, 1: byte write strobe to the writable instruction memory array.
REQ-010 Port mem_addr, output, ROM_WIDTH: byte offset of the write.
REQ-011 Port mem_wdata, output, 8: byte to write.
REQ-012 Port cpu_hold, output, 1: holds the CPU in reset or stall while a load is in progress or has failed.
REQ-013 Port done, output, 1: level signal; the last session completed cleanly.
REQ-014 Port err, output, 1: level signal; the last session failed.

Function
REQ-015 Stream format is LEN_HI, LEN_LO, L data bytes, then CHK, where L = {LEN_HI, LEN_LO} and CHK is the XOR of all data bytes.
REQ-016 Data byte k is written to offset k; byte 0 of each word lands at the lowest offset, because the fetch side forms each instruction as {m[a], m[a+1], m[a+2], m[a+3]}.
REQ-017 The state machine has states IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE and ERR.
REQ-018 Transitions on start: IDLE, DONE or ERR go to LEN_HI.
REQ-019 Transitions on each accepted byte:
- LEN_HI goes to LEN_LO.
- LEN_LO goes to CHK if L==0, to ERR if L > 2**ROM_WIDTH or L mod 4 != 0, and to DATA otherwise.
- DATA goes to CHK after the L-th byte.
- CHK goes to DONE on a match and to ERR on a mismatch.
REQ-020 rx_ready is 1 only in LEN_HI, LEN_LO, DATA and CHK; it is combinational from state.
REQ-021 Write latency is one cycle: a DATA byte accepted in cycle n produces mem_we=1 in cycle n+1, with mem_addr=k and mem_wdata equal to that byte.
REQ-022 mem_we is 0 in every cycle that does not follow a DATA acceptance.
REQ-023 Throughput is one byte per cycle; back-to-back acceptances are allowed.
REQ-024 The byte counter is 13 bits wide (ROM_WIDTH+1) so that L=4096 does not wrap.
REQ-025 mem_addr is the low ROM_WIDTH bits of the counter and never wraps within a legal session.
REQ-026 The running XOR clears on entry to LEN_HI.
REQ-027 cpu_hold is 1 in every state except DONE.
REQ-028 done is 1 only in DONE; err is 1 only in ERR.
REQ-029 rx_valid is ignored in IDLE, DONE and ERR.
REQ-030 A start pulse during LEN_HI through CHK is ignored; the session continues.
REQ-031 A start pulse in the same cycle as the CHK acceptance is ignored; the FSM enters DONE or ERR.
REQ-032 Memory already written by a failed session is not restored; err together with cpu_hold blocks execution.

Reset
REQ-033 When rst is high at a clock edge, the FSM enters IDLE and the counter and running XOR clear.
REQ-034 On reset, mem_we, done and err go to 0, and cpu_hold goes to 1.
REQ-035 Reset has priority over start and over any byte transfer in the same cycle, including reset in mid-DATA.
REQ-036 A write pending from the previous cycle's acceptance is dropped by reset: mem_we is 0 in the cycle after rst.

Structure
REQ-037 Package instr_loader_pkg holds:
- the state enum type loader_state_t;
- the constant ROM_BASE = 32'hBFC00000, used by the system map and not by the loader's addressing;
- the constant ROM_BYTES = 4096.
REQ-038 The block has no sub-module: a single FSM, a counter, an XOR register and a one-stage write register.

Verification
REQ-039 Scenario: start, then stream 00 04 DE AD BE EF 22 -> mem writes 0:DE, 1:AD, 2:BE, 3:EF at one per cycle, each one cycle after its acceptance; done=1, cpu_hold=0.
REQ-040 Scenario: stream 00 00 00 -> DONE with no mem_we pulses.
REQ-041 Scenario: stream 10 01 -> ERR right after LEN_LO; err=1, cpu_hold=1, no writes.
REQ-042 Scenario: stream 00 04 01 02 03 04 FF -> four writes, then ERR, since the correct checksum is 04.
REQ-043 Scenario: full 4096-byte load of pattern k&FF with CHK 00 -> last write at offset FFF, no wrap, done=1.
REQ-044 Scenario: rst asserted after 2 of 8 data bytes, then start and a fresh 4-byte load -> IDLE after reset, no write from the byte accepted in the reset cycle, and the second load writes from offset 0.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared types and constants for the instruction loader
package instr_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_t;

    // System-map location of the instruction memory; the loader itself uses offsets only.
    localparam logic [31:0] ROM_BASE  = 32'hBFC00000;
    localparam int          ROM_BYTES = 4096;

endpackage

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream loader for the writable instruction memory
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ROM_WIDTH  = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic                 rx_ready,
    output logic                 mem_we,
    output logic [ROM_WIDTH-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 err
);

    // Capacity and word alignment used to validate the announced length.
    localparam logic [31:0] CAPACITY   = 32'(1) << ROM_WIDTH;
    localparam logic [15:0] ALIGN_MASK = 16'(DATA_WIDTH / 8 - 1);

    loader_state_t state, state_next;

    logic [15:0]        len;
    logic [ROM_WIDTH:0] cnt;
    logic [ROM_WIDTH:0] cnt_next;
    logic [7:0]         xor_acc;
    logic               wr_valid;
    logic [ROM_WIDTH-1:0] wr_addr;
    logic [7:0]         wr_data;

    logic        accept;
    logic        begin_session;
    logic [15:0] len_full;
    logic        len_bad;
    logic        last_byte;

    assign rx_ready = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                      (state == ST_DATA)   || (state == ST_CHK);
    assign accept   = rx_valid && rx_ready;
    assign begin_session = start &&
                      ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));

    // Length as seen while the low byte is on the bus; the high byte is already held.
    assign len_full  = {len[15:8], rx_data};
    assign len_bad   = ({16'd0, len_full} > CAPACITY) || ((len_full & ALIGN_MASK) != 16'd0);
    assign cnt_next  = cnt + 1'b1;
    assign last_byte = (cnt_next == len[ROM_WIDTH:0]);

    assign mem_we    = wr_valid;
    assign mem_addr  = wr_addr;
    assign mem_wdata = wr_data;
    assign cpu_hold  = (state != ST_DONE);
    assign done      = (state == ST_DONE);
    assign err       = (state == ST_ERR);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start only from idle/terminal states, otherwise advance per accepted byte.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (accept) state_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (accept) begin
                    if (len_full == 16'd0) state_next = ST_CHK;
                    else if (len_bad)      state_next = ST_ERR;
                    else                   state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept && last_byte) state_next = ST_CHK;
            end
            ST_CHK: begin
                if (accept) state_next = (rx_data == xor_acc) ? ST_DONE : ST_ERR;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Length capture, byte counter, running checksum and the one-stage write register.
    always_ff @(posedge clk) begin
        if (rst) begin
            len      <= '0;
            cnt      <= '0;
            xor_acc  <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_valid <= 1'b0;
            if (begin_session) begin
                cnt     <= '0;
                xor_acc <= '0;
            end
            if (accept) begin
                case (state)
                    ST_LEN_HI: len[15:8] <= rx_data;
                    ST_LEN_LO: len[7:0]  <= rx_data;
                    ST_DATA: begin
                        wr_valid <= 1'b1;
                        wr_addr  <= cnt[ROM_WIDTH-1:0];
                        wr_data  <= rx_data;
                        xor_acc  <= xor_acc ^ rx_data;
                        cnt      <= cnt_next;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
